wb_32bit_fifo_reader: RTL and testbench
=======================================

// Module: wb_32bit_fifo_reader
// PURPOSE
//  Testbench-side Wishbone slave that drains a 32-bit FIFO: each data-bus read pops one
//  word and returns it. A status bus reports fill level, empty and sticky error flags.
//  Sits downstream of the FIFO that the Wishbone FIFO writer fills. Stalls on empty,
//  with an optional timeout that ends the cycle with err.
// PARAMETERS
//  ADR_W        4     FIFO address width; rd_num_i is ADR_W+1 bits wide (0..2**ADR_W)
//  TIMEOUT_CYC  1024  max stall cycles on empty before wbd_err_o; 0 = wait forever
// PORTS
//  clk_i       in   1        clock
//  rst_i       in   1        reset, asynchronous, active-high
//  wbd_cyc_i   in   1        data bus cycle
//  wbd_stb_i   in   1        data bus strobe
//  wbd_we_i    in   1        data bus write enable (writes are acked, ignored)
//  wbd_dat_o   out  32       popped FIFO word
//  wbd_ack_o   out  1        data bus ack
//  wbd_err_o   out  1        data bus error (timeout)
//  wbs_cyc_i   in   1        status bus cycle
//  wbs_stb_i   in   1        status bus strobe
//  wbs_we_i    in   1        status write: clears sticky flags, data ignored
//  wbs_ack_o   out  1        status bus ack
//  wbs_dat_o   out  32       {'0, abort_f, tmo_f, rd_num_i, rd_empty_i}
//  rd_ena_o    out  1        FIFO pop, one-cycle pulse
//  rd_dat_i    in   32       FIFO read data, valid the cycle after rd_ena_o
//  rd_empty_i  in   1        FIFO empty
//  rd_num_i    in   ADR_W+1  FIFO fill level
// BEHAVIOUR
//  Reset: state=IDLE; wbd_dat_o=0, wbd_ack_o=0, wbd_err_o=0, rd_ena_o=0, wbs_ack_o=0,
//   tmo_f=0, abort_f=0, timeout count=0.
//  FSM (registered state; all outputs are decoded from state or registered):
//   IDLE:   cyc&stb&we -> ACK_WR; cyc&stb&!we -> (rd_empty_i ? WAIT : POP).
//   WAIT:   count++ each cycle. !cyc -> IDLE (no pop). !rd_empty_i -> POP.
//           TIMEOUT_CYC!=0 and count==TIMEOUT_CYC-1 -> ERR. count clears on exit.
//   POP:    rd_ena_o=1 -> LATCH.
//   LATCH:  wbd_dat_o<=rd_dat_i. cyc -> ACK; !cyc -> IDLE with abort_f<=1
//           (the word is discarded).
//   ACK:    wbd_ack_o=1 -> IDLE.   ACK_WR: wbd_ack_o=1 -> IDLE.
//   ERR:    wbd_err_o=1, tmo_f<=1 -> IDLE.
//  Latency: read with the FIFO non-empty = strobe sampled at edge N, rd_ena_o high at N+1,
//   ack high at N+3. One IDLE cycle between back-to-back transfers.
//  Empty takes priority over the timeout: if rd_empty_i falls in the same cycle the count
//   expires, go to POP.
//  wbd_dat_o holds its last popped value between reads. A write never pops the FIFO.
//  Exactly one rd_ena_o per acked read. rd_ena_o is never asserted while rd_empty_i=1.
//  Status bus: wbs_ack_o is a one-cycle pulse the cycle after cyc&stb&!wbs_ack_o, then
//   forced low for one cycle. wbs_dat_o is combinational from current flags and FIFO inputs.
//   A status write clears tmo_f and abort_f on the ack cycle. If a flag is set in the same
//   cycle it is cleared, set wins.
//  Reset mid-transfer returns to IDLE immediately. A popped but unacked word is lost.
// STRUCTURE
//  wb_fifo_pkg: state enum, status bit positions (EMPTY_B=0, NUM_LSB=1, TMO_B, ABORT_B
//   derived from ADR_W via localparam functions), default TIMEOUT_CYC.
//  Sub-module wb_fifo_timeout_cnt (inputs en/clr, parameter TIMEOUT_CYC, output expire).
//   Width is $clog2(TIMEOUT_CYC+1). Tied expire=0 when TIMEOUT_CYC==0.
//  Remainder (FSM, data register, status slave) in this module.
// TESTING
//  1 FIFO preloaded 0xA5A5_0001..0003; three reads -> data in order, ack at N+3 each,
//    3 rd_ena_o pulses, rd_num_i 3->0.
//  2 Read with FIFO empty, push 0xDEAD_BEEF after 10 cycles -> no ack while empty,
//    rd_ena_o once, ack with 0xDEAD_BEEF, tmo_f=0.
//  3 TIMEOUT_CYC=16, read empty FIFO -> wbd_err_o one cycle after 16 WAIT cycles;
//    status reads bit TMO_B=1; status write then read -> 0.
//  4 Data-bus write 0x1234_5678 -> ack after 1 cycle, rd_ena_o never high,
//    rd_num_i unchanged.
//  5 Drop wbd_cyc_i during LATCH -> no ack, abort_f=1, FIFO count decremented by 1.
//  6 Assert rst_i during WAIT and during POP -> all outputs 0 next cycle.
//    Next read proceeds normally.

Source files
------------

// File: rtl/wb_fifo_pkg.sv
// wb_fifo_pkg
// Shared definitions for the Wishbone FIFO reader: FSM state encodings,
// status word bit positions and the default empty-stall timeout.
// No ports (package).

package wb_fifo_pkg;

    // State encodings kept as plain constants so older code that compares
    // against raw 3-bit values keeps working.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_WAIT   = 3'd1;
    localparam state_t ST_POP    = 3'd2;
    localparam state_t ST_LATCH  = 3'd3;
    localparam state_t ST_ACK    = 3'd4;
    localparam state_t ST_ACK_WR = 3'd5;
    localparam state_t ST_ERR    = 3'd6;

    // Status word layout: {'0, abort_f, tmo_f, rd_num, rd_empty}
    localparam int EMPTY_B = 0;
    localparam int NUM_LSB = 1;

    localparam int DEFAULT_TIMEOUT_CYC = 1024;

    // The fill level is ADR_W+1 bits wide, so the flag positions move with ADR_W.
    function automatic int tmo_bit(input int adr_w);
        return NUM_LSB + adr_w + 1;
    endfunction

    function automatic int abort_bit(input int adr_w);
        return tmo_bit(adr_w) + 1;
    endfunction

endpackage

// File: rtl/wb_fifo_timeout_cnt.sv
// wb_fifo_timeout_cnt
// Counts consecutive enabled cycles and flags the cycle in which the count
// reaches TIMEOUT_CYC-1. With TIMEOUT_CYC == 0 the counter is removed and
// expire is tied low (wait forever).
// Ports:
//   clk_i   in  clock
//   rst_i   in  asynchronous active-high reset
//   en      in  count this cycle
//   clr     in  synchronous clear (has priority over en)
//   expire  out high while enabled and the count is at its last value

module wb_fifo_timeout_cnt
    import wb_fifo_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en,
    input  logic clr,
    output logic expire
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk_i, rst_i, en, clr};
            assign expire        = 1'b0;
        end else begin : g_on
            localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

            logic [CNT_W-1:0] count;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    count <= '0;
                end else if (clr) begin
                    count <= '0;
                end else if (en) begin
                    count <= count + CNT_W'(1);
                end
            end

            // The owner leaves the counting state on expire, so the count
            // never runs past LAST.
            assign expire = en && (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/wb_32bit_fifo_reader.sv
// wb_32bit_fifo_reader
// Wishbone slave that drains a 32-bit FIFO: every data-bus read pops one word
// and returns it; data-bus writes are acknowledged and ignored. A read on an
// empty FIFO stalls until data arrives or, if TIMEOUT_CYC != 0, until the
// stall budget runs out and the cycle ends with an error. A second Wishbone
// port reports the fill level, empty and two sticky flags (timeout, abort);
// any write to it clears the flags.
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   wbd_cyc_i/stb_i/we_i      data bus request
//   wbd_dat_o/ack_o/err_o     data bus response (popped word, ack, timeout error)
//   wbs_cyc_i/stb_i/we_i      status bus request
//   wbs_ack_o/dat_o           status bus response
//   rd_ena_o                  FIFO pop pulse
//   rd_dat_i                  FIFO data, valid the cycle after rd_ena_o
//   rd_empty_i, rd_num_i      FIFO empty flag and fill level

module wb_32bit_fifo_reader
    import wb_fifo_pkg::*;
#(
    parameter int ADR_W       = 4,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             wbd_cyc_i,
    input  logic             wbd_stb_i,
    input  logic             wbd_we_i,
    output logic [31:0]      wbd_dat_o,
    output logic             wbd_ack_o,
    output logic             wbd_err_o,

    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,

    output logic             rd_ena_o,
    input  logic [31:0]      rd_dat_i,
    input  logic             rd_empty_i,
    input  logic [ADR_W:0]   rd_num_i
);

    localparam int TMO_B   = tmo_bit(ADR_W);
    localparam int ABORT_B = abort_bit(ADR_W);

    state_t state;
    state_t next_state;

    logic dat_req;
    logic expire;
    logic wbs_req;
    logic flag_clr;
    logic tmo_set;
    logic abort_set;
    logic tmo_f;
    logic abort_f;

    assign dat_req = wbd_cyc_i & wbd_stb_i;

    // Inside WAIT a dropped cycle wins over everything, and data arriving wins
    // over an expiring timeout.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (dat_req) begin
                    if (wbd_we_i) begin
                        next_state = ST_ACK_WR;
                    end else if (rd_empty_i) begin
                        next_state = ST_WAIT;
                    end else begin
                        next_state = ST_POP;
                    end
                end
            end
            ST_WAIT: begin
                if (!wbd_cyc_i) begin
                    next_state = ST_IDLE;
                end else if (!rd_empty_i) begin
                    next_state = ST_POP;
                end else if (expire) begin
                    next_state = ST_ERR;
                end
            end
            ST_POP:    next_state = ST_LATCH;
            ST_LATCH:  next_state = wbd_cyc_i ? ST_ACK : ST_IDLE;
            ST_ACK:    next_state = ST_IDLE;
            ST_ACK_WR: next_state = ST_IDLE;
            ST_ERR:    next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A word popped for a master that has already gone away is dropped, so
    // the last successfully returned word stays visible.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wbd_dat_o <= '0;
        end else if ((state == ST_LATCH) && wbd_cyc_i) begin
            wbd_dat_o <= rd_dat_i;
        end
    end

    assign rd_ena_o  = (state == ST_POP);
    assign wbd_ack_o = (state == ST_ACK) || (state == ST_ACK_WR);
    assign wbd_err_o = (state == ST_ERR);

    wb_fifo_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en     (state == ST_WAIT),
        .clr    (state != ST_WAIT),
        .expire (expire)
    );

    // Status port: single-cycle ack, then one forced-low cycle before a held
    // request can be acked again.
    assign wbs_req = wbs_cyc_i & wbs_stb_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wbs_ack_o <= 1'b0;
        end else begin
            wbs_ack_o <= wbs_req & ~wbs_ack_o;
        end
    end

    assign flag_clr  = wbs_ack_o & wbs_req & wbs_we_i;
    assign tmo_set   = (state == ST_ERR);
    assign abort_set = (state == ST_LATCH) && !wbd_cyc_i;

    // Setting takes priority so an event that coincides with a clear is not lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_f   <= 1'b0;
            abort_f <= 1'b0;
        end else begin
            if (tmo_set) begin
                tmo_f <= 1'b1;
            end else if (flag_clr) begin
                tmo_f <= 1'b0;
            end
            if (abort_set) begin
                abort_f <= 1'b1;
            end else if (flag_clr) begin
                abort_f <= 1'b0;
            end
        end
    end

    always_comb begin
        wbs_dat_o                       = '0;
        wbs_dat_o[EMPTY_B]              = rd_empty_i;
        wbs_dat_o[NUM_LSB +: ADR_W + 1] = rd_num_i;
        wbs_dat_o[TMO_B]                = tmo_f;
        wbs_dat_o[ABORT_B]              = abort_f;
    end

endmodule

// File: tb/tb_wb_32bit_fifo_reader.sv
// tb_wb_32bit_fifo_reader
// Directed bench for wb_32bit_fifo_reader with a small FIFO model on the read
// side. The DUT runs with ADR_W=4 and TIMEOUT_CYC=16, so the status word is
// {'0, abort(bit7), tmo(bit6), num(bits5:1), empty(bit0)}.

module tb_wb_32bit_fifo_reader;

    localparam int ADR_W = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wbd_cyc = 1'b0;
    logic        wbd_stb = 1'b0;
    logic        wbd_we  = 1'b0;
    logic [31:0] wbd_dat;
    logic        wbd_ack;
    logic        wbd_err;
    logic        wbs_cyc = 1'b0;
    logic        wbs_stb = 1'b0;
    logic        wbs_we  = 1'b0;
    logic        wbs_ack;
    logic [31:0] wbs_dat;
    logic        rd_ena;
    logic [31:0] rd_dat = '0;
    logic        rd_empty;
    logic [4:0]  rd_num;

    logic        push_en  = 1'b0;
    logic [31:0] push_dat = '0;
    logic [31:0] mem [0:31];
    logic [4:0]  wptr = '0;
    logic [4:0]  rptr = '0;
    logic [4:0]  fifo_cnt = '0;
    int          empty_pops = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_32bit_fifo_reader #(
        .ADR_W       (ADR_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wbd_cyc_i  (wbd_cyc),
        .wbd_stb_i  (wbd_stb),
        .wbd_we_i   (wbd_we),
        .wbd_dat_o  (wbd_dat),
        .wbd_ack_o  (wbd_ack),
        .wbd_err_o  (wbd_err),
        .wbs_cyc_i  (wbs_cyc),
        .wbs_stb_i  (wbs_stb),
        .wbs_we_i   (wbs_we),
        .wbs_ack_o  (wbs_ack),
        .wbs_dat_o  (wbs_dat),
        .rd_ena_o   (rd_ena),
        .rd_dat_i   (rd_dat),
        .rd_empty_i (rd_empty),
        .rd_num_i   (rd_num)
    );

    // FIFO model: data appears the cycle after the pop.
    always @(posedge clk) begin
        if (rd_ena) begin
            rd_dat <= mem[rptr];
            rptr   <= rptr + 5'd1;
            if (fifo_cnt == 5'd0) empty_pops <= empty_pops + 1;
        end
        if (push_en) begin
            mem[wptr] <= push_dat;
            wptr      <= wptr + 5'd1;
        end
        fifo_cnt <= fifo_cnt + {4'd0, push_en} - {4'd0, rd_ena};
    end

    assign rd_empty = (fifo_cnt == 5'd0);
    assign rd_num   = fifo_cnt;

    task automatic push_word(input logic [31:0] w);
        push_en  = 1'b1;
        push_dat = w;
        @(negedge clk);
        push_en  = 1'b0;
    endtask

    // Read until ack/err or max_cyc; holds the request through the ack edge.
    task automatic bus_read(input int max_cyc, output logic [31:0] data,
                            output int lat, output logic got_err, output int enas);
        bit done;
        done = 0; lat = -1; enas = 0; got_err = 1'b0; data = '0;
        wbd_cyc = 1'b1; wbd_stb = 1'b1; wbd_we = 1'b0;
        for (int i = 1; i <= max_cyc && !done; i++) begin
            @(negedge clk);
            if (rd_ena) enas++;
            if (wbd_ack || wbd_err) begin
                done = 1; lat = i; data = wbd_dat; got_err = wbd_err;
            end
        end
        @(negedge clk);
        wbd_cyc = 1'b0; wbd_stb = 1'b0;
    endtask

    task automatic bus_write(output int lat, output int enas);
        bit done;
        done = 0; lat = -1; enas = 0;
        wbd_cyc = 1'b1; wbd_stb = 1'b1; wbd_we = 1'b1;
        for (int i = 1; i <= 10 && !done; i++) begin
            @(negedge clk);
            if (rd_ena) enas++;
            if (wbd_ack) begin done = 1; lat = i; end
        end
        @(negedge clk);
        wbd_cyc = 1'b0; wbd_stb = 1'b0; wbd_we = 1'b0;
    endtask

    task automatic status_access(input logic we, output logic [31:0] data,
                                 output int lat, output logic ack_after);
        bit done;
        done = 0; lat = -1; data = '0;
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we;
        for (int i = 1; i <= 5 && !done; i++) begin
            @(negedge clk);
            if (wbs_ack) begin done = 1; lat = i; data = wbs_dat; end
        end
        @(negedge clk);
        ack_after = wbs_ack;
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({wbd_ack, wbd_err, rd_ena, wbs_ack} !== 4'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000", {wbd_ack, wbd_err, rd_ena, wbs_ack});
        end
        checks++;
        if (wbd_dat !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_dat: got %h expected 00000000", wbd_dat);
        end
        checks++;
        if (wbs_dat !== 32'h1) begin
            errors++; $display("[TB] FAIL reset_status: got %h expected 00000001", wbs_dat);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_burst_reads();
        logic [31:0] d;
        int lat, enas, total;
        logic e;
        total = 0;
        push_word(32'hA5A5_0001);
        push_word(32'hA5A5_0002);
        push_word(32'hA5A5_0003);
        checks++;
        if (rd_num !== 5'd3) begin
            errors++; $display("[TB] FAIL burst_num_pre: got %0d expected 3", rd_num);
        end
        for (int k = 0; k < 3; k++) begin
            bus_read(10, d, lat, e, enas);
            total += enas;
            checks++;
            if (d !== 32'hA5A5_0001 + k) begin
                errors++; $display("[TB] FAIL burst_data%0d: got %h expected %h", k, d, 32'hA5A5_0001 + k);
            end
            checks++;
            if (lat !== 3 || e !== 1'b0) begin
                errors++; $display("[TB] FAIL burst_lat%0d: got %0d err %b expected 3 err 0", k, lat, e);
            end
        end
        checks++;
        if (total !== 3) begin
            errors++; $display("[TB] FAIL burst_pops: got %0d expected 3", total);
        end
        checks++;
        if (rd_num !== 5'd0 || rd_empty !== 1'b1) begin
            errors++; $display("[TB] FAIL burst_num_post: got %0d empty %b expected 0 empty 1", rd_num, rd_empty);
        end
    endtask

    task automatic test_empty_wait();
        logic [31:0] d, s;
        int lat, enas, slat;
        logic e, aa;
        fork
            bus_read(40, d, lat, e, enas);
            begin
                repeat (10) @(negedge clk);
                push_word(32'hDEAD_BEEF);
            end
        join
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            errors++; $display("[TB] FAIL wait_data: got %h expected deadbeef", d);
        end
        checks++;
        if (lat !== 14 || e !== 1'b0 || enas !== 1) begin
            errors++; $display("[TB] FAIL wait_timing: got lat %0d err %b pops %0d expected 14 0 1", lat, e, enas);
        end
        status_access(1'b0, s, slat, aa);
        checks++;
        if (s !== 32'h0000_0001) begin
            errors++; $display("[TB] FAIL wait_status: got %h expected 00000001", s);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d, s;
        int lat, enas, slat;
        logic e, aa;
        bus_read(40, d, lat, e, enas);
        checks++;
        if (e !== 1'b1 || lat !== 17 || enas !== 0) begin
            errors++; $display("[TB] FAIL tmo_err: got err %b lat %0d pops %0d expected 1 17 0", e, lat, enas);
        end
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            errors++; $display("[TB] FAIL tmo_hold: got %h expected deadbeef", d);
        end
        status_access(1'b0, s, slat, aa);
        checks++;
        if (s !== 32'h0000_0041 || slat !== 1) begin
            errors++; $display("[TB] FAIL tmo_status: got %h lat %0d expected 00000041 lat 1", s, slat);
        end
        checks++;
        if (aa !== 1'b0) begin
            errors++; $display("[TB] FAIL status_ack_gap: got %b expected 0", aa);
        end
        status_access(1'b1, s, slat, aa);
        status_access(1'b0, s, slat, aa);
        checks++;
        if (s !== 32'h0000_0001) begin
            errors++; $display("[TB] FAIL tmo_clear: got %h expected 00000001", s);
        end
    endtask

    task automatic test_write();
        int lat, enas;
        push_word(32'h1111_0000);
        bus_write(lat, enas);
        checks++;
        if (lat !== 1 || enas !== 0) begin
            errors++; $display("[TB] FAIL write_ack: got lat %0d pops %0d expected 1 0", lat, enas);
        end
        checks++;
        if (rd_num !== 5'd1 || wbd_dat !== 32'hDEAD_BEEF) begin
            errors++; $display("[TB] FAIL write_side: got num %0d dat %h expected 1 deadbeef", rd_num, wbd_dat);
        end
    endtask

    task automatic test_abort();
        logic [31:0] d, s;
        int lat, enas, slat, acks;
        logic e, aa;
        push_word(32'h2222_0000);
        acks = 0;
        wbd_cyc = 1'b1; wbd_stb = 1'b1; wbd_we = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_ena !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_pop: got %b expected 1", rd_ena);
        end
        @(negedge clk);
        wbd_cyc = 1'b0; wbd_stb = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (wbd_ack) acks++;
        end
        checks++;
        if (acks !== 0 || rd_num !== 5'd1) begin
            errors++; $display("[TB] FAIL abort_noack: got acks %0d num %0d expected 0 1", acks, rd_num);
        end
        status_access(1'b0, s, slat, aa);
        checks++;
        if (s !== 32'h0000_0082) begin
            errors++; $display("[TB] FAIL abort_status: got %h expected 00000082", s);
        end
        status_access(1'b1, s, slat, aa);
        status_access(1'b0, s, slat, aa);
        checks++;
        if (s !== 32'h0000_0002) begin
            errors++; $display("[TB] FAIL abort_clear: got %h expected 00000002", s);
        end
        bus_read(10, d, lat, e, enas);
        checks++;
        if (d !== 32'h2222_0000 || lat !== 3) begin
            errors++; $display("[TB] FAIL abort_next: got %h lat %0d expected 22220000 lat 3", d, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, s;
        int lat, enas, slat;
        logic e, aa;
        wbd_cyc = 1'b1; wbd_stb = 1'b1; wbd_we = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1; wbd_cyc = 1'b0; wbd_stb = 1'b0;
        @(negedge clk);
        checks++;
        if ({wbd_ack, wbd_err, rd_ena, wbs_ack} !== 4'b0 || wbd_dat !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_wait: got ctrl %b dat %h expected 0000 00000000", {wbd_ack, wbd_err, rd_ena, wbs_ack}, wbd_dat);
        end
        rst = 1'b0;
        @(negedge clk);
        push_word(32'h600D_F00D);
        wbd_cyc = 1'b1; wbd_stb = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_ena !== 1'b1) begin
            errors++; $display("[TB] FAIL rst_pop_pre: got %b expected 1", rd_ena);
        end
        rst = 1'b1; wbd_cyc = 1'b0; wbd_stb = 1'b0;
        @(negedge clk);
        checks++;
        if ({wbd_ack, wbd_err, rd_ena, wbs_ack} !== 4'b0 || rd_num !== 5'd1) begin
            errors++;
            $display("[TB] FAIL rst_pop: got ctrl %b num %0d expected 0000 1", {wbd_ack, wbd_err, rd_ena, wbs_ack}, rd_num);
        end
        rst = 1'b0;
        @(negedge clk);
        status_access(1'b0, s, slat, aa);
        checks++;
        if (s !== 32'h0000_0002) begin
            errors++; $display("[TB] FAIL rst_status: got %h expected 00000002", s);
        end
        bus_read(10, d, lat, e, enas);
        checks++;
        if (d !== 32'h600D_F00D || lat !== 3 || enas !== 1) begin
            errors++; $display("[TB] FAIL rst_next: got %h lat %0d pops %0d expected 600df00d 3 1", d, lat, enas);
        end
    endtask

    task automatic test_no_empty_pop();
        checks++;
        if (empty_pops !== 0) begin
            errors++; $display("[TB] FAIL empty_pop: got %0d expected 0", empty_pops);
        end
    endtask

    initial begin
        test_reset();
        test_burst_reads();
        test_empty_wait();
        test_timeout();
        test_write();
        test_abort();
        test_reset_mid();
        test_no_empty_pop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
